// File: rtl/svc_soc_io_arb.sv
// Two-master arbiter for the SoC I/O register bus: one grant per cycle, registered
// downstream command, read data steered back to the master that issued the read.
module svc_soc_io_arb #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          RR         = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            io_ren,
    output logic [AW-1:0]   io_raddr,
    input  logic [DW-1:0]   io_rdata,
    output logic            io_wen,
    output logic [AW-1:0]   io_waddr,
    output logic [DW-1:0]   io_wdata,
    output logic [DW/8-1:0] io_wstrb
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = 4;

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           owner_q;
    logic           last_gnt_q;
    logic           io_ren_q;
    logic           io_wen_q;
    logic [AW-1:0]  io_raddr_q;
    logic [AW-1:0]  io_waddr_q;
    logic [DW-1:0]  io_wdata_q;
    logic [SW-1:0]  io_wstrb_q;

    logic           rd_done;
    logic           grant_ok;
    logic           pick1;
    logic           any_gnt;
    logic           win_we;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_wdata;
    logic [SW-1:0]  win_wstrb;

    // Read data lands when the counter has run out; a new grant may go out that same cycle.
    assign rd_done  = (state_q == RD_WAIT) && (cnt_q == '0);
    assign grant_ok = !rst && ((state_q == IDLE) || rd_done);
    assign pick1    = m1_req && (!m0_req || (RR && !last_gnt_q));

    assign m0_gnt   = grant_ok && m0_req && !pick1;
    assign m1_gnt   = grant_ok && pick1;
    assign any_gnt  = m0_gnt || m1_gnt;

    assign win_we    = pick1 ? m1_we    : m0_we;
    assign win_addr  = pick1 ? m1_addr  : m0_addr;
    assign win_wdata = pick1 ? m1_wdata : m0_wdata;
    assign win_wstrb = pick1 ? m1_wstrb : m0_wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            io_ren_q   <= 1'b0;
            io_wen_q   <= 1'b0;
            io_raddr_q <= '0;
            io_waddr_q <= '0;
            io_wdata_q <= '0;
            io_wstrb_q <= '0;
        end else begin
            io_ren_q <= 1'b0;
            io_wen_q <= 1'b0;
            if ((state_q == RD_WAIT) && !rd_done) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (rd_done) begin
                state_q <= IDLE;
            end
            if (any_gnt) begin
                last_gnt_q <= pick1;
                if (win_we) begin
                    io_wen_q   <= 1'b1;
                    io_waddr_q <= win_addr;
                    io_wdata_q <= win_wdata;
                    io_wstrb_q <= win_wstrb;
                end else begin
                    io_ren_q   <= 1'b1;
                    io_raddr_q <= win_addr;
                    state_q    <= RD_WAIT;
                    cnt_q      <= CW'(RD_LATENCY);
                    owner_q    <= pick1;
                end
            end
        end
    end

    assign io_ren   = io_ren_q;
    assign io_raddr = io_raddr_q;
    assign io_wen   = io_wen_q;
    assign io_waddr = io_waddr_q;
    assign io_wdata = io_wdata_q;
    assign io_wstrb = io_wstrb_q;

    assign m0_rvalid = rd_done && !owner_q;
    assign m1_rvalid = rd_done && owner_q;
    assign m0_rdata  = m0_rvalid ? io_rdata : '0;
    assign m1_rdata  = m1_rvalid ? io_rdata : '0;

    // Masters must hold a request until granted; the bus never carries read and write at once.
    a_m0_hold: assert property (@(posedge clk) disable iff (rst) (m0_req && !m0_gnt) |=> m0_req)
        else $error("m0_req dropped before grant");
    a_m1_hold: assert property (@(posedge clk) disable iff (rst) (m1_req && !m1_gnt) |=> m1_req)
        else $error("m1_req dropped before grant");
    a_rw_excl: assert property (@(posedge clk) disable iff (rst) !(io_ren && io_wen))
        else $error("io_ren and io_wen both high");
    a_gnt_one: assert property (@(posedge clk) disable iff (rst) !(m0_gnt && m1_gnt))
        else $error("both grants high");

endmodule

// File: tb/tb_svc_soc_io_arb.sv
// Bench for svc_soc_io_arb: instance 0 is RR=1/RD_LATENCY=1, instance 1 is RR=0/RD_LATENCY=3,
// each with its own small register bank model.
module tb_svc_soc_io_arb;
    logic        clk;
    logic        rst;
    logic        req   [2][2];
    logic        we    [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [3:0]  strb  [2][2];
    logic        gnt   [2][2];
    logic        rvalid[2][2];
    logic [31:0] rdata [2][2];
    logic        io_ren   [2];
    logic        io_wen   [2];
    logic [31:0] io_raddr [2];
    logic [31:0] io_waddr [2];
    logic [31:0] io_wdata [2];
    logic [31:0] io_rdata [2];
    logic [3:0]  io_wstrb [2];
    logic [31:0] mem [2][16];
    logic        pv  [2][16];
    logic [31:0] pa  [2][16];
    int total;
    int bad;

    function automatic logic [31:0] init_val(input int i);
        return (i == 1) ? 32'h0000_1234 : (32'hC0DE_0000 | 32'(i));
    endfunction

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : 3;
        assign io_rdata[g] = pv[g][L-1] ? mem[g][pa[g][L-1][5:2]] : 32'hDEAD_BEEF;
        svc_soc_io_arb #(.AW(32), .DW(32), .RD_LATENCY(L), .RR((g == 0) ? 1'b1 : 1'b0)) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_addr(addr[g][0]),
            .m0_wdata(wdata[g][0]), .m0_wstrb(strb[g][0]),
            .m0_gnt(gnt[g][0]), .m0_rvalid(rvalid[g][0]), .m0_rdata(rdata[g][0]),
            .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_addr(addr[g][1]),
            .m1_wdata(wdata[g][1]), .m1_wstrb(strb[g][1]),
            .m1_gnt(gnt[g][1]), .m1_rvalid(rvalid[g][1]), .m1_rdata(rdata[g][1]),
            .io_ren(io_ren[g]), .io_raddr(io_raddr[g]), .io_rdata(io_rdata[g]),
            .io_wen(io_wen[g]), .io_waddr(io_waddr[g]), .io_wdata(io_wdata[g]),
            .io_wstrb(io_wstrb[g])
        );
    end

    // Register bank: read data appears exactly RD_LATENCY cycles after io_ren
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) begin
                    mem[g][k] <= init_val(k);
                    pv[g][k]  <= 1'b0;
                    pa[g][k]  <= 32'h0;
                end
            end else begin
                pv[g][0] <= io_ren[g];
                pa[g][0] <= io_raddr[g];
                for (int k = 1; k < 16; k++) begin
                    pv[g][k] <= pv[g][k-1];
                    pa[g][k] <= pa[g][k-1];
                end
                if (io_wen[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (io_wstrb[g][b]) mem[g][io_waddr[g][5:2]][8*b +: 8] <= io_wdata[g][8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input int m, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req[g][m] = r; we[g][m] = w; addr[g][m] = a; wdata[g][m] = d; strb[g][m] = s;
    endtask

    task automatic idle_all();
        for (int g = 0; g < 2; g++)
            for (int m = 0; m < 2; m++) drive(g, m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct { logic r0; logic r1; logic e0; logic e1; } vec_t;
    vec_t tbl [14];

    logic        exp_v [2];
    int          exp_m [2];
    int          exp_due [2];
    logic [31:0] exp_d [2];
    logic [31:0] sh [2][16];
    int          wt [2][2];
    logic        done [2][2];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        logic pend_w;
        logic [31:0] pe_a, pe_d;
        logic [3:0] pe_s;
        total = 0;
        bad = 0;
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state, with a request already pending
        rst = 1'b1;
        idle_all();
        req[0][0] = 1'b1;
        req[1][1] = 1'b1;
        step();
        for (int g = 0; g < 2; g++) begin
            chk("rst_ren", io_ren[g], 0);
            chk("rst_wen", io_wen[g], 0);
            for (int m = 0; m < 2; m++) begin
                chk("rst_gnt", gnt[g][m], 0);
                chk("rst_rvalid", rvalid[g][m], 0);
            end
        end
        idle_all();
        step();
        rst = 1'b0;

        // m1 read on instance 0, latency 1
        step();
        drive(0, 1, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
        #1;
        chk("rd_gnt1", gnt[0][1], 1);
        chk("rd_gnt0", gnt[0][0], 0);
        step();
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("rd_ren", io_ren[0], 1);
        chk("rd_raddr", io_raddr[0], 32'h8000_0004);
        chk("rd_early_rvalid", rvalid[0][1], 0);
        step();
        chk("rd_rvalid1", rvalid[0][1], 1);
        chk("rd_rdata1", rdata[0][1], 32'h0000_1234);
        chk("rd_rvalid0", rvalid[0][0], 0);
        chk("rd_rdata0", rdata[0][0], 0);
        chk("rd_ren_off", io_ren[0], 0);
        step();
        chk("rd_rvalid_pulse", rvalid[0][1], 0);

        // Write arbitration table on instance 0 (round-robin)
        n0 = 0; n1 = 0; pend_w = 1'b0; pe_a = 0; pe_d = 0; pe_s = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("tbl_wen", io_wen[0], pend_w);
            chk("tbl_ren", io_ren[0], 0);
            if (pend_w) begin
                chk("tbl_waddr", io_waddr[0], pe_a);
                chk("tbl_wdata", io_wdata[0], pe_d);
                chk("tbl_wstrb", io_wstrb[0], pe_s);
            end
            drive(0, 0, tbl[i].r0, 1'b1, 32'h8000_0000 + 32'(n0 * 4), 32'hA5 + 32'(n0), 4'h1);
            drive(0, 1, tbl[i].r1, 1'b1, 32'h9000_0000 + 32'(n1 * 4), 32'h5A00_0000 + 32'(n1), 4'hC);
            #1;
            chk("tbl_gnt0", gnt[0][0], tbl[i].e0);
            chk("tbl_gnt1", gnt[0][1], tbl[i].e1);
            pend_w = tbl[i].e0 | tbl[i].e1;
            if (tbl[i].e0) begin
                pe_a = addr[0][0]; pe_d = wdata[0][0]; pe_s = strb[0][0]; n0++;
            end else if (tbl[i].e1) begin
                pe_a = addr[0][1]; pe_d = wdata[0][1]; pe_s = strb[0][1]; n1++;
            end
        end
        step();
        idle_all();
        chk("tbl_wen_end", io_wen[0], pend_w);

        // Instance 1 (latency 3): m0 read blocks a pending m1 write until read data returns
        step();
        drive(1, 0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
        drive(1, 1, 1'b1, 1'b1, 32'h9000_0010, 32'h77, 4'hF);
        #1;
        chk("l3_gnt0", gnt[1][0], 1);
        chk("l3_gnt1_n0", gnt[1][1], 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) req[1][0] = 1'b0;
            chk("l3_ren", io_ren[1], (k == 1) ? 32'd1 : 32'd0);
            chk("l3_rvalid_wait", rvalid[1][0], 0);
            #1;
            chk("l3_gnt1_blocked", gnt[1][1], 0);
        end
        step();
        chk("l3_rvalid", rvalid[1][0], 1);
        chk("l3_rdata", rdata[1][0], init_val(2));
        #1;
        chk("l3_gnt1", gnt[1][1], 1);
        step();
        req[1][1] = 1'b0;
        chk("l3_wen", io_wen[1], 1);
        chk("l3_waddr", io_waddr[1], 32'h9000_0010);
        chk("l3_ren_off", io_ren[1], 0);
        chk("l3_rvalid_off", rvalid[1][0], 0);

        // Instance 1 fixed priority: 6 tied writes all go to m0
        for (int k = 0; k < 6; k++) begin
            step();
            if (k > 0) chk("fp_waddr", io_waddr[1], 32'h8000_0100 + 32'((k - 1) * 4));
            drive(1, 0, 1'b1, 1'b1, 32'h8000_0100 + 32'(k * 4), 32'h100 + 32'(k), 4'hF);
            drive(1, 1, 1'b1, 1'b1, 32'h9000_0100, 32'h200, 4'hF);
            #1;
            chk("fp_gnt0", gnt[1][0], 1);
            chk("fp_gnt1", gnt[1][1], 0);
        end
        step();
        req[1][0] = 1'b0;
        #1;
        chk("fp_gnt1_last", gnt[1][1], 1);
        step();
        req[1][1] = 1'b0;
        chk("fp_wen_m1", io_wen[1], 1);
        chk("fp_waddr_m1", io_waddr[1], 32'h9000_0100);

        // Reset one cycle after a read grant on instance 0
        step();
        drive(0, 0, 1'b1, 1'b0, 32'h8000_000C, 32'h0, 4'h0);
        #1;
        chk("rr_gnt0", gnt[0][0], 1);
        step();
        rst = 1'b1;
        idle_all();
        #1;
        chk("rr_ren", io_ren[0], 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_rvalid0", rvalid[0][0], 0);
            chk("rr_rvalid1", rvalid[0][1], 0);
            chk("rr_ren_post", io_ren[0], 0);
        end
        drive(0, 0, 1'b1, 1'b1, 32'h8000_0020, 32'h11, 4'hF);
        drive(0, 1, 1'b1, 1'b1, 32'h9000_0020, 32'h22, 4'hF);
        #1;
        chk("rr_tie_gnt0", gnt[0][0], 1);
        chk("rr_tie_gnt1", gnt[0][1], 0);
        step();
        req[0][0] = 1'b0;
        #1;
        chk("rr_tie2_gnt1", gnt[0][1], 1);
        step();
        req[0][1] = 1'b0;

        // Random mixed traffic on both instances against a shadow-memory scoreboard
        do_reset();
        for (int g = 0; g < 2; g++) begin
            exp_v[g] = 1'b0; exp_m[g] = 0; exp_due[g] = 0; exp_d[g] = 0;
            for (int i = 0; i < 16; i++) sh[g][i] = init_val(i);
            for (int m = 0; m < 2; m++) begin wt[g][m] = 0; done[g][m] = 1'b0; end
        end
        for (int c = 0; c < 10100; c++) begin
            step();
            for (int g = 0; g < 2; g++) begin
                chk("rnd_rw_excl", io_ren[g] & io_wen[g], 0);
                for (int m = 0; m < 2; m++) begin
                    logic erv;
                    erv = exp_v[g] && (exp_m[g] == m) && (c == exp_due[g]);
                    chk("rnd_rvalid", rvalid[g][m], erv);
                    chk("rnd_rdata", rdata[g][m], erv ? exp_d[g] : 32'h0);
                end
                if (exp_v[g] && c >= exp_due[g]) exp_v[g] = 1'b0;
                for (int m = 0; m < 2; m++) begin
                    if (done[g][m]) begin req[g][m] = 1'b0; done[g][m] = 1'b0; end
                    if (req[g][m]) begin
                        wt[g][m]++;
                        chk("rnd_req_served", wt[g][m] < 200, 1);
                    end else if (c < 10000 && $urandom_range(1, 0) == 1) begin
                        drive(g, m, 1'b1, 1'($urandom_range(1, 0)),
                              32'h8000_0000 | (32'($urandom_range(15, 0)) << 2),
                              $urandom, 4'($urandom_range(15, 1)));
                        wt[g][m] = 0;
                    end
                end
            end
            #1;
            for (int g = 0; g < 2; g++) begin
                chk("rnd_one_gnt", gnt[g][0] & gnt[g][1], 0);
                for (int m = 0; m < 2; m++) begin
                    chk("rnd_gnt_no_req", gnt[g][m] & ~req[g][m], 0);
                    if (gnt[g][m] && req[g][m] && !done[g][m]) begin
                        chk("rnd_gnt_in_wait", exp_v[g], 0);
                        if (we[g][m]) begin
                            for (int b = 0; b < 4; b++)
                                if (strb[g][m][b]) sh[g][addr[g][m][5:2]][8*b +: 8] = wdata[g][m][8*b +: 8];
                        end else begin
                            exp_v[g] = 1'b1;
                            exp_m[g] = m;
                            exp_d[g] = sh[g][addr[g][m][5:2]];
                            exp_due[g] = c + 1 + lat(g);
                        end
                        done[g][m] = 1'b1;
                    end
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            chk("rnd_drain_read", exp_v[g], 0);
            for (int m = 0; m < 2; m++) chk("rnd_drain_req", req[g][m] & ~done[g][m], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
